memory_bus_sequencer: RTL and testbench

Converts a single-cycle read/write request, presented with the address from the address bus multiplexer, into a timed external asynchronous SRAM cycle. It sits directly downstream of the address bus mux and owns the CE/OE/WE/byte-enable strobes, the configurable wait states, byte-lane steering and read-data capture. The control unit sees a simple accept/DONE handshake.

---
 rtl/memory_bus_sequencer_pkg.sv | 34 +++
 rtl/memory_bus_sequencer_wait_state_counter.sv | 25 ++
 rtl/memory_bus_sequencer.sv | 140 ++++++++++++++
 tb/tb_memory_bus_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_sequencer_pkg.sv
// Shared state encodings, byte-enable constants and lane-steering helpers
// for the asynchronous SRAM bus sequencer.
package memory_bus_sequencer_pkg;

   typedef enum logic [1:0] {
      MBS_IDLE   = 2'd0,
      MBS_SETUP  = 2'd1,
      MBS_ACCESS = 2'd2,
      MBS_HOLD   = 2'd3
   } mbs_state_e;

   // Active-low byte enables: BE_LO enables only the low lane, BE_HI only the high lane.
   localparam logic [1:0] BE_WORD = 2'b00;
   localparam logic [1:0] BE_LO   = 2'b10;
   localparam logic [1:0] BE_HI   = 2'b01;
   localparam logic [1:0] BE_NONE = 2'b11;

   function automatic logic [1:0] be_select(input logic is_write, input logic byte_acc,
                                            input logic a0);
      if (!is_write || !byte_acc) return BE_WORD;
      return a0 ? BE_HI : BE_LO;
   endfunction

   function automatic logic [15:0] write_lanes(input logic byte_acc, input logic [15:0] data);
      return byte_acc ? {data[7:0], data[7:0]} : data;
   endfunction

   function automatic logic [15:0] read_steer(input logic byte_acc, input logic a0,
                                              input logic [15:0] data);
      if (!byte_acc) return data;
      return a0 ? {8'h00, data[15:8]} : {8'h00, data[7:0]};
   endfunction

endpackage

// File: rtl/memory_bus_sequencer_wait_state_counter.sv
// 3-bit down-counter that times the ACCESS phase; zero marks the final
// ACCESS cycle.
module wait_state_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [2:0] load_value,
   input  logic       dec,
   output logic       zero
);

   logic [2:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= 3'd0;
      else if (load)
         count <= load_value;
      else if (dec && count != 3'd0)
         count <= count - 3'd1;
   end

   assign zero = (count == 3'd0);

endmodule

// File: rtl/memory_bus_sequencer.sv
// Turns a single-cycle read/write request into a timed asynchronous SRAM cycle
// (SETUP, ACCESS x (WAIT_STATES+1), HOLD) with byte-lane steering and read capture.
module memory_bus_sequencer
   import memory_bus_sequencer_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] ADDR,
   input  logic [15:0] DIN,
   input  logic        RD_REQ,
   input  logic        WR_REQ,
   input  logic        BYTEX,
   output logic        BUSY,
   output logic        DONE,
   output logic        BUS_ERR,
   output logic [15:0] DOUT,
   output logic [14:0] MEM_ADDR,
   output logic        MEM_CE_N,
   output logic        MEM_OE_N,
   output logic        MEM_WE_N,
   output logic [1:0]  MEM_BE_N,
   output logic [15:0] MEM_DOUT,
   output logic        MEM_DOE,
   input  logic [15:0] MEM_DIN,
   output mbs_state_e  DBG_STATE
);

   // Handshake: RD_REQ/WR_REQ are sampled only in IDLE or HOLD (BUSY=0); an accepted
   // request yields exactly one DONE pulse in HOLD, a rejected one exactly one BUS_ERR
   // pulse on the following cycle. The requester holds its request until BUSY=0.

   localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

   mbs_state_e state_q, state_d;
   logic       byte_q, a0_q, wr_q;
   logic       req_ok, req_bad;
   logic       accept, reject;
   logic       cnt_load, cnt_dec, cnt_zero;

   assign req_ok  = (RD_REQ ^ WR_REQ) & ~(~BYTEX & ADDR[0]);
   assign req_bad = (RD_REQ | WR_REQ) & ~req_ok;

   wait_state_counter u_wait_state_counter (
      .clk        (CLK),
      .reset      (RESET),
      .load       (cnt_load),
      .load_value (WS_LOAD),
      .dec        (cnt_dec),
      .zero       (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      reject   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         MBS_IDLE: begin
            if (req_ok) begin
               state_d = MBS_SETUP;
               accept  = 1'b1;
            end else begin
               reject  = req_bad;
            end
         end
         MBS_SETUP: begin
            state_d  = MBS_ACCESS;
            cnt_load = 1'b1;
         end
         MBS_ACCESS: begin
            if (cnt_zero) state_d = MBS_HOLD;
            else          cnt_dec = 1'b1;
         end
         MBS_HOLD: begin
            if (req_ok) begin
               state_d = MBS_SETUP;
               accept  = 1'b1;
            end else begin
               state_d = MBS_IDLE;
               reject  = req_bad;
            end
         end
         default: state_d = MBS_IDLE;
      endcase
   end

   // Every output is registered from the next state so that no request input
   // reaches a MEM_* pin combinationally.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= MBS_IDLE;
         byte_q   <= 1'b0;
         a0_q     <= 1'b0;
         wr_q     <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         BUS_ERR  <= 1'b0;
         DOUT     <= 16'h0000;
         MEM_ADDR <= 15'h0000;
         MEM_CE_N <= 1'b1;
         MEM_OE_N <= 1'b1;
         MEM_WE_N <= 1'b1;
         MEM_BE_N <= BE_NONE;
         MEM_DOUT <= 16'h0000;
         MEM_DOE  <= 1'b0;
      end else begin
         state_q  <= state_d;
         BUSY     <= (state_d == MBS_SETUP) || (state_d == MBS_ACCESS);
         DONE     <= (state_d == MBS_HOLD);
         BUS_ERR  <= reject;
         MEM_OE_N <= ~((state_d == MBS_ACCESS) && !wr_q);
         MEM_WE_N <= ~((state_d == MBS_ACCESS) && wr_q);

         if (accept) begin
            byte_q   <= BYTEX;
            a0_q     <= ADDR[0];
            wr_q     <= WR_REQ;
            MEM_ADDR <= ADDR[15:1];
            MEM_DOUT <= write_lanes(BYTEX, DIN);
            MEM_BE_N <= be_select(WR_REQ, BYTEX, ADDR[0]);
            MEM_DOE  <= WR_REQ;
            MEM_CE_N <= 1'b0;
         end else if (state_d == MBS_IDLE) begin
            MEM_CE_N <= 1'b1;
            MEM_BE_N <= BE_NONE;
            MEM_DOE  <= 1'b0;
         end

         // Capture on the edge that closes the last ACCESS cycle.
         if (state_q == MBS_ACCESS && cnt_zero && !wr_q)
            DOUT <= read_steer(byte_q, a0_q, MEM_DIN);
      end
   end

   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_memory_bus_sequencer.sv
// Directed bench for memory_bus_sequencer: three instances with WAIT_STATES 0, 1, 2,
// a scoreboard queue of expected DONE/BUS_ERR events and per-cycle strobe checks.
module tb_memory_bus_sequencer;

   logic clk = 1'b0;
   logic rst;

   logic [2:0]        rd_req, wr_req, bytex;
   logic [2:0][15:0]  addr, din, mem_din;
   logic [2:0]        busy, done, bus_err, ce_n, oe_n, we_n, doe;
   logic [2:0][15:0]  dout, mem_dout;
   logic [2:0][14:0]  mem_addr;
   logic [2:0][1:0]   be_n, dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   // {instance, kind, dout}: kind 1 = DONE, 2 = BUS_ERR (dout ignored, stored as 0)
   logic [19:0] exp_q[$];
   logic [19:0] mon_act;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      memory_bus_sequencer #(.WAIT_STATES(g)) u_dut (
         .CLK       (clk),
         .RESET     (rst),
         .ADDR      (addr[g]),
         .DIN       (din[g]),
         .RD_REQ    (rd_req[g]),
         .WR_REQ    (wr_req[g]),
         .BYTEX     (bytex[g]),
         .BUSY      (busy[g]),
         .DONE      (done[g]),
         .BUS_ERR   (bus_err[g]),
         .DOUT      (dout[g]),
         .MEM_ADDR  (mem_addr[g]),
         .MEM_CE_N  (ce_n[g]),
         .MEM_OE_N  (oe_n[g]),
         .MEM_WE_N  (we_n[g]),
         .MEM_BE_N  (be_n[g]),
         .MEM_DOUT  (mem_dout[g]),
         .MEM_DOE   (doe[g]),
         .MEM_DIN   (mem_din[g]),
         .DBG_STATE (dbg_state[g])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] strobes(input int g);
      return {ce_n[g], oe_n[g], we_n[g], be_n[g], doe[g]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_evt(input int g, input int kind, input logic [15:0] d);
      exp_q.push_back({2'(g), 2'(kind), d});
   endtask

   task automatic issue(input int g, input logic rd, input logic wr, input logic bx,
                        input logic [15:0] a, input logic [15:0] d);
      rd_req[g] = rd;
      wr_req[g] = wr;
      bytex[g]  = bx;
      addr[g]   = a;
      din[g]    = d;
      tick();
      rd_req[g] = 1'b0;
      wr_req[g] = 1'b0;
   endtask

   // Walks forward from cycle 'start' until DONE, counting strobe-active cycles.
   task automatic observe(input int g, input int start, output int done_cyc,
                          output int oe_cnt, output int we_cnt, output int doe_cnt);
      done_cyc = -1;
      oe_cnt   = 0;
      we_cnt   = 0;
      doe_cnt  = 0;
      for (int c = start; c < start + 16; c++) begin
         if (oe_n[g] === 1'b0) oe_cnt++;
         if (we_n[g] === 1'b0) we_cnt++;
         if (doe[g] === 1'b1)  doe_cnt++;
         if (done[g] === 1'b1) begin
            done_cyc = c;
            break;
         end
         tick();
      end
   endtask

   // Monitor: every DONE or BUS_ERR pulse must match the head of the queue.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int g = 0; g < 3; g++) begin
            if (done[g] === 1'b1 || bus_err[g] === 1'b1) begin
               mon_act = {2'(g), bus_err[g], done[g], (done[g] === 1'b1) ? dout[g] : 16'h0000};
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_event: got %h, expected no event", mon_act);
               end else begin
                  check("scoreboard_event", 32'(mon_act), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc, dc1, oe_c, we_c, doe_c;
      rd_req = '0; wr_req = '0; bytex = '0;
      addr = '0; din = '0; mem_din = '0;
      rst = 1'b1;
      tick();
      tick();
      for (int g = 0; g < 3; g++) begin
         check("reset_strobes", strobes(g), 6'b111110);
         check("reset_data", {mem_addr[g], mem_dout[g], dout[g]}, 47'h0);
         check("reset_status", {busy[g], done[g], bus_err[g], dbg_state[g]}, 5'b0);
      end
      rst = 1'b0;
      tick();

      // Word read, W=1
      mem_din[1] = 16'hBEEF;
      expect_evt(1, 1, 16'hBEEF);
      issue(1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
      check("rd_setup_state", dbg_state[1], 2'd1);
      check("rd_mem_addr", mem_addr[1], 15'h091A);
      check("rd_setup_strobes", strobes(1), 6'b011000);
      check("rd_busy", busy[1], 1'b1);
      observe(1, 1, dc, oe_c, we_c, doe_c);
      check("rd_done_cycle", dc, 4);
      check("rd_oe_cycles", oe_c, 2);
      check("rd_dout", dout[1], 16'hBEEF);
      tick();
      check("rd_idle_strobes", strobes(1), 6'b111110);
      check("rd_idle_state", dbg_state[1], 2'd0);

      // Byte write, odd address, W=0
      expect_evt(0, 1, 16'h0000);
      issue(0, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h00A5);
      check("bw_mem_dout", mem_dout[0], 16'hA5A5);
      check("bw_setup_strobes", strobes(0), 6'b011011);
      observe(0, 1, dc, oe_c, we_c, doe_c);
      check("bw_done_cycle", dc, 3);
      check("bw_we_cycles", we_c, 1);
      check("bw_doe_cycles", doe_c, 3);
      check("bw_oe_cycles", oe_c, 0);
      tick();
      check("bw_idle_strobes", strobes(0), 6'b111110);

      // Byte read, odd address, W=1
      mem_din[1] = 16'h7F20;
      expect_evt(1, 1, 16'h007F);
      issue(1, 1'b1, 1'b0, 1'b1, 16'h0021, 16'h0000);
      check("br_odd_be", be_n[1], 2'b00);
      observe(1, 1, dc, oe_c, we_c, doe_c);
      check("br_odd_done_cycle", dc, 4);
      check("br_odd_dout", dout[1], 16'h007F);
      tick();

      // Byte read, even address, W=0
      mem_din[0] = 16'h7F20;
      expect_evt(0, 1, 16'h0020);
      issue(0, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000);
      observe(0, 1, dc, oe_c, we_c, doe_c);
      check("br_even_done_cycle", dc, 3);
      check("br_even_dout", dout[0], 16'h0020);
      tick();

      // Word write, W=2
      expect_evt(2, 1, 16'h0000);
      issue(2, 1'b0, 1'b1, 1'b0, 16'h0200, 16'hC3D2);
      check("ww_mem_dout", mem_dout[2], 16'hC3D2);
      check("ww_be", be_n[2], 2'b00);
      check("ww_mem_addr", mem_addr[2], 15'h0100);
      observe(2, 1, dc, oe_c, we_c, doe_c);
      check("ww_done_cycle", dc, 5);
      check("ww_we_cycles", we_c, 3);
      check("ww_doe_cycles", doe_c, 5);
      tick();

      // Reject: misaligned word read
      expect_evt(1, 2, 16'h0000);
      issue(1, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000);
      check("rej_align_c1", {bus_err[1], busy[1], ce_n[1], dbg_state[1]}, 5'b10100);
      tick();
      check("rej_align_c2", {bus_err[1], ce_n[1]}, 2'b01);

      // Reject: read and write together
      expect_evt(1, 2, 16'h0000);
      issue(1, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h0000);
      check("rej_both_c1", {bus_err[1], busy[1], ce_n[1], dbg_state[1]}, 5'b10100);
      tick();
      check("rej_both_c2", {bus_err[1], ce_n[1]}, 2'b01);

      // Back-to-back reads, W=2, second request held in HOLD
      mem_din[2] = 16'h1111;
      expect_evt(2, 1, 16'h1111);
      issue(2, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
      observe(2, 1, dc1, oe_c, we_c, doe_c);
      check("b2b_first_done", dc1, 5);
      mem_din[2] = 16'h2222;
      expect_evt(2, 1, 16'h2222);
      issue(2, 1'b1, 1'b0, 1'b0, 16'h0102, 16'h0000);
      check("b2b_second_setup", dbg_state[2], 2'd1);
      check("b2b_second_addr", mem_addr[2], 15'h0081);
      observe(2, 6, dc, oe_c, we_c, doe_c);
      check("b2b_done_spacing", dc - dc1, 5);
      check("b2b_second_dout", dout[2], 16'h2222);
      tick();

      // Reset in the 2nd ACCESS cycle of a write, W=1
      issue(1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h1357);
      tick();
      tick();
      check("rst_mid_state", {dbg_state[1], we_n[1]}, 3'b100);
      rst = 1'b1;
      tick();
      check("rst_mid_strobes", strobes(1), 6'b111110);
      check("rst_mid_status", {busy[1], done[1], bus_err[1], dbg_state[1]}, 5'b0);
      check("rst_mid_dout", dout[1], 16'h0000);
      rst = 1'b0;
      repeat (4) tick();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
